// File: rtl/ahb_tgen_pkg.sv
// Shared encodings for the AHB-lite write/read-back traffic generator.
// Holds the bus constants, the FSM state type and the data pattern.
package ahb_tgen_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_GAP   = 3'd2,
    ST_READ  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // Word written to (and expected back from) transfer index idx.
  function automatic logic [31:0] tgen_pattern(input logic [15:0] idx);
    return {~idx, idx};
  endfunction

endpackage

// File: rtl/ahb_tgen_chk.sv
// Read-back checker: compares completed read data against the index pattern
// and keeps a saturating mismatch count.
module ahb_tgen_chk
  import ahb_tgen_pkg::*;
#(
  parameter int P_DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            valid_i,
  input  logic [15:0]     idx_i,
  input  logic [P_DW-1:0] rdata_i,
  output logic [15:0]     err_cnt_o
);

  logic [15:0] err_cnt_q, err_cnt_d;
  logic        mismatch;

  assign mismatch = valid_i && (rdata_i != P_DW'(tgen_pattern(idx_i)));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_i) begin
      err_cnt_d = '0;
    end else if (mismatch && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/ahb_tgen.sv
// AHB-lite single master: writes N pattern words, idles P_GAP cycles, then
// reads them back and counts mismatches.
module ahb_tgen
  import ahb_tgen_pkg::*;
#(
  parameter int P_AW  = 32,
  parameter int P_DW  = 32,
  parameter int P_GAP = 4
) (
  input  logic            HRESETn,
  input  logic            HCLK,
  input  logic            start,
  input  logic [P_AW-1:0] base_addr,
  input  logic [15:0]     num_words,
  output logic [P_AW-1:0] HADDR,
  output logic [1:0]      HTRANS,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [P_DW-1:0] HWDATA,
  input  logic [P_DW-1:0] HRDATA,
  input  logic [1:0]      HRESP,
  input  logic            HREADY,
  output logic            busy,
  output logic            done,
  output logic [15:0]     err_cnt,
  output logic            resp_err
);

  state_e          state_q, state_d;
  logic [P_AW-1:0] base_q, base_d;
  logic [15:0]     num_q, num_d;
  logic [15:0]     aidx_q, aidx_d;
  logic [1:0]      htrans_q, htrans_d;
  logic [P_AW-1:0] haddr_q, haddr_d;
  logic            hwrite_q, hwrite_d;
  logic [P_DW-1:0] hwdata_q, hwdata_d;
  logic            dp_valid_q, dp_valid_d;
  logic            dp_write_q, dp_write_d;
  logic [15:0]     dp_idx_q, dp_idx_d;
  logic [3:0]      gap_q, gap_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            resp_err_q, resp_err_d;
  logic            chk_clr;

  // Handshake: an address phase is accepted on a rising edge with
  // HTRANS=NONSEQ and HREADY=1; the pending data phase completes on the
  // first rising edge with HREADY=1. Nothing on the bus moves otherwise.
  logic addr_acc, dp_done, last_addr, rd_check;
  logic [P_AW-1:0] base_aligned;

  assign addr_acc     = HREADY && (htrans_q == HTRANS_NONSEQ);
  assign dp_done      = HREADY && dp_valid_q;
  assign last_addr    = (aidx_q == (num_q - 16'd1));
  assign rd_check     = dp_done && !dp_write_q;
  assign base_aligned = base_addr & ~P_AW'(3);

  function automatic logic [P_AW-1:0] word_addr(input logic [P_AW-1:0] base,
                                                input logic [15:0]     idx);
    return base + P_AW'({idx, 2'b00});
  endfunction

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    aidx_d     = aidx_q;
    htrans_d   = htrans_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    gap_d      = gap_q;
    busy_d     = busy_q;
    done_d     = done_q;
    resp_err_d = resp_err_q;
    chk_clr    = 1'b0;

    if (dp_done) begin
      dp_valid_d = 1'b0;
      if (HRESP != HRESP_OKAY) resp_err_d = 1'b1;
    end
    // An accepted address becomes the next data phase; write data follows it.
    if (addr_acc) begin
      dp_valid_d = 1'b1;
      dp_write_d = hwrite_q;
      dp_idx_d   = aidx_q;
      if (hwrite_q) hwdata_d = P_DW'(tgen_pattern(aidx_q));
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_aligned;
          num_d      = num_words;
          done_d     = 1'b0;
          resp_err_d = 1'b0;
          chk_clr    = 1'b1;
          if (num_words == 16'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d   = 1'b1;
            state_d  = ST_WRITE;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b1;
            haddr_d  = base_aligned;
            aidx_d   = '0;
          end
        end
      end
      ST_WRITE: begin
        if (addr_acc) begin
          if (last_addr) begin
            state_d  = ST_GAP;
            htrans_d = HTRANS_IDLE;
            hwrite_d = 1'b0;
            gap_d    = '0;
          end else begin
            aidx_d  = aidx_q + 16'd1;
            haddr_d = word_addr(base_q, aidx_q + 16'd1);
          end
        end
      end
      ST_GAP: begin
        // Idle cycles only count once the final write data phase is done.
        if (!dp_valid_q) begin
          if (gap_q == 4'(P_GAP - 1)) begin
            state_d  = ST_READ;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b0;
            haddr_d  = base_q;
            aidx_d   = '0;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
      end
      ST_READ: begin
        if (addr_acc) begin
          if (last_addr) begin
            state_d  = ST_FLUSH;
            htrans_d = HTRANS_IDLE;
          end else begin
            aidx_d  = aidx_q + 16'd1;
            haddr_d = word_addr(base_q, aidx_q + 16'd1);
          end
        end
      end
      ST_FLUSH: begin
        if (dp_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      aidx_q     <= '0;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      aidx_q     <= aidx_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      resp_err_q <= resp_err_d;
    end
  end

  ahb_tgen_chk #(
    .P_DW (P_DW)
  ) u_chk (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .clr_i     (chk_clr),
    .valid_i   (rd_check),
    .idx_i     (dp_idx_q),
    .rdata_i   (HRDATA),
    .err_cnt_o (err_cnt)
  );

  assign HADDR    = haddr_q;
  assign HTRANS   = htrans_q;
  assign HWRITE   = hwrite_q;
  assign HSIZE    = HSIZE_WORD;
  assign HBURST   = HBURST_SINGLE;
  assign HWDATA   = hwdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign resp_err = resp_err_q;

endmodule

// File: tb/tb_ahb_tgen.sv
// Bench for ahb_tgen: behavioural memory slave with wait states, read
// corruption and ERROR injection, checked against a transfer-list model.
module tb_ahb_tgen;

  localparam int P_GAP = 4;

  // clock / reset
  logic        HCLK      = 1'b0;
  logic        HRESETn   = 1'b1;
  logic        start     = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA    = '0;
  logic [1:0]  HRESP     = 2'b00;
  logic        HREADY    = 1'b1;
  logic        busy;
  logic        done;
  logic [15:0] err_cnt;
  logic        resp_err;

  always #5 HCLK = ~HCLK;

  ahb_tgen #(
    .P_AW  (32),
    .P_DW  (32),
    .P_GAP (P_GAP)
  ) dut (
    .HRESETn   (HRESETn),
    .HCLK      (HCLK),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .HREADY    (HREADY),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt),
    .resp_err  (resp_err)
  );

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] obs_waddr[$];
  logic [31:0] obs_wdata[$];
  logic [31:0] obs_raddr[$];
  logic [31:0] mem [logic [31:0]];

  // slave configuration and monitors
  bit          cor_mask  [0:255];
  bit          err_wmask [0:255];
  int          wait_min = 0;
  int          wait_max = 0;
  int          wcnt = 0, rcnt = 0;
  int          busy_cycles = 0, idle_busy = 0, stray_trans = 0, bad_ctrl = 0;
  int          stall_bad = 0, stalls = 0;
  bit          pend = 0, pend_wr = 0, pend_err = 0, prev_stall = 0;
  logic [31:0] pend_addr = '0;
  int          pend_idx = 0, wait_left = 0;
  logic [66:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: decides HREADY/HRESP/HRDATA for the current cycle at the
  // falling edge, so the DUT sees them settled at the next rising edge.
  initial forever begin
    @(negedge HCLK or negedge HRESETn);
    if (!HRESETn) begin
      pend = 0; wait_left = 0; prev_stall = 0;
      HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    end else begin
      if (prev_stall && ({HADDR, HTRANS, HWRITE, HWDATA} !== held)) stall_bad++;
      if (busy) busy_cycles++;
      if (busy && HTRANS == 2'b00) idle_busy++;
      if (!busy && HTRANS != 2'b00) stray_trans++;
      if (HTRANS != 2'b00 && HTRANS != 2'b10) bad_ctrl++;
      if (pend && wait_left > 0) begin
        HREADY = 1'b0;
        HRESP  = (pend_err && wait_left == 1) ? 2'b01 : 2'b00;
        wait_left--;
        stalls++;
      end else begin
        HREADY = 1'b1;
        HRESP  = (pend && pend_err) ? 2'b01 : 2'b00;
        if (pend) begin
          if (pend_wr) begin
            mem[pend_addr] = HWDATA;
            obs_wdata.push_back(HWDATA);
          end else begin
            HRDATA = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
            if (cor_mask[pend_idx]) HRDATA[0] = ~HRDATA[0];
          end
        end
        pend = 0;
        if (HTRANS == 2'b10) begin
          pend = 1; pend_addr = HADDR; pend_wr = HWRITE;
          if (HSIZE != 3'b010 || HBURST != 3'b000) bad_ctrl++;
          if (HWRITE) begin
            pend_idx = wcnt; pend_err = err_wmask[wcnt & 255]; wcnt++;
            obs_waddr.push_back(HADDR);
          end else begin
            pend_idx = rcnt; pend_err = 0; rcnt++;
            obs_raddr.push_back(HADDR);
          end
          pend_idx  = pend_idx & 255;
          wait_left = int'($urandom_range(wait_max, wait_min)) + (pend_err ? 1 : 0);
        end
      end
      prev_stall = !HREADY;
      held = {HADDR, HTRANS, HWRITE, HWDATA};
    end
  end

  // driver tasks
  task automatic clear_cfg();
    for (int i = 0; i < 256; i++) begin
      cor_mask[i] = 0;
      err_wmask[i] = 0;
    end
    obs_waddr.delete(); obs_wdata.delete(); obs_raddr.delete();
    mem.delete();
    wcnt = 0; rcnt = 0; stall_bad = 0; stalls = 0;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    @(negedge HCLK);
    base_addr = b; num_words = n; start = 1'b1;
    busy_cycles = 0; idle_busy = 0;
    @(negedge HCLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge HCLK);
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    chk({tag, "_haddr"}, HADDR, 32'd0);
    chk({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
    chk({tag, "_hsize"}, 32'(HSIZE), 32'd2);
    chk({tag, "_hburst"}, 32'(HBURST), 32'd0);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_resperr"}, 32'(resp_err), 32'd0);
  endtask

  // Model: transfer i goes to aligned base + 4*i with data {~i, i}; the
  // mismatch count is the number of corrupted reads, resp_err any ERROR.
  task automatic run_case(input string tag, input logic [31:0] base, input int n,
                          input int wmin, input int wmax, input bit poke);
    int exp_err = 0;
    bit exp_resp = 0;
    exp_q.delete(); exp_wd_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back((base & 32'hFFFF_FFFC) + 32'(4 * i));
      exp_wd_q.push_back({~16'(i), 16'(i)});
      if (cor_mask[i]) exp_err++;
      if (err_wmask[i]) exp_resp = 1;
    end
    wait_min = wmin; wait_max = wmax;
    do_start(base, 16'(n));
    if (poke) begin
      repeat (2) @(negedge HCLK);
      start = 1'b1; num_words = 16'd1; base_addr = 32'h0;
      @(negedge HCLK);
      start = 1'b0;
    end
    wait_done(tag, 40 * n + 100);
    chk({tag, "_nw"}, 32'(obs_waddr.size()), 32'(n));
    chk({tag, "_nr"}, 32'(obs_raddr.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_wa%0d", tag, i), (i < obs_waddr.size()) ? obs_waddr[i] : 32'hDEAD_0001, exp_q[i]);
      chk($sformatf("%s_wd%0d", tag, i), (i < obs_wdata.size()) ? obs_wdata[i] : 32'hDEAD_0002, exp_wd_q[i]);
      chk($sformatf("%s_ra%0d", tag, i), (i < obs_raddr.size()) ? obs_raddr[i] : 32'hDEAD_0003, exp_q[i]);
    end
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_resperr"}, 32'(resp_err), 32'(exp_resp));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
    if (wmax == 0 && !exp_resp) begin
      chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(2 * n + 2 + P_GAP));
      chk({tag, "_idle_busy"}, 32'(idle_busy), 32'(P_GAP + 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    // reset state
    #1 HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    check_reset_vals("rst");
    #2 HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);
    chk("rst_no_xfer", 32'(obs_waddr.size() + obs_raddr.size()), 32'd0);

    // empty run
    clear_cfg();
    do_start(32'h200, 16'd0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge HCLK);
    chk("n0_no_xfer", 32'(obs_waddr.size() + obs_raddr.size()), 32'd0);

    // zero-wait directed run
    clear_cfg();
    run_case("d4", 32'h100, 4, 0, 0, 0);
    chk("d4_wd0_const", obs_wdata[0], 32'hFFFF_0000);
    chk("d4_wd3_const", obs_wdata[3], 32'hFFFC_0003);
    chk("d4_wa3_const", obs_waddr[3], 32'h0000_010C);

    // two wait states on every transfer
    clear_cfg();
    run_case("wait2", 32'h1000, 3, 2, 2, 0);
    chk("wait2_stalls_seen", 32'(stalls > 0), 32'd1);

    // corrupted read of index 2, plus a start pulse while busy
    clear_cfg();
    cor_mask[2] = 1;
    run_case("corrupt", 32'h2001, 8, 0, 1, 1);
    chk("corrupt_errcnt_const", 32'(err_cnt), 32'd1);

    // ERROR response on write index 1
    clear_cfg();
    err_wmask[1] = 1;
    run_case("resp", 32'h300, 2, 0, 0, 0);
    chk("resp_flag_const", 32'(resp_err), 32'd1);

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      clear_cfg();
      n = int'($urandom_range(20, 1));
      for (int i = 0; i < n; i++) begin
        cor_mask[i]  = ($urandom_range(3, 0) == 0);
        err_wmask[i] = ($urandom_range(7, 0) == 0);
      end
      run_case($sformatf("rnd%0d", r), $urandom, n, 0, int'($urandom_range(2, 0)), 0);
    end

    // reset in the middle of the read phase
    clear_cfg();
    cor_mask[0] = 1;
    wait_min = 0; wait_max = 0;
    do_start(32'h4000, 16'd16);
    cyc = 0;
    while (obs_raddr.size() < 4 && cyc < 400) begin
      @(negedge HCLK);
      cyc++;
    end
    chk("mid_in_read", 32'(obs_raddr.size() >= 4), 32'd1);
    chk("mid_errcnt_pre", 32'(err_cnt), 32'd1);
    #2 HRESETn = 1'b0;
    #1 check_reset_vals("mid");
    repeat (2) @(negedge HCLK);
    #2 HRESETn = 1'b1;
    obs_waddr.delete(); obs_wdata.delete(); obs_raddr.delete();
    repeat (10) @(negedge HCLK);
    chk("mid_no_xfer", 32'(obs_waddr.size() + obs_raddr.size()), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);

    // recovery run after the reset
    clear_cfg();
    run_case("post", 32'h8000, 5, 0, 0, 0);

    chk("stray_trans", 32'(stray_trans), 32'd0);
    chk("bad_ctrl", 32'(bad_ctrl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
